// File: rtl/jump_index_encoder.sv
`timescale 1ns/1ps
// jump_index_encoder
// Turns a jump target byte address into the 26-bit J/JAL instr_index field.
// It flags word misalignment and 256 MB region mismatch against pc_plus4.
// Results are buffered in a 2-entry FIFO with registered outputs.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready comes from the registered fill state only, and out_* come
// from the registered head entry. Neither side has a combinational path to
// the other. Once out_valid is high, the head fields hold until it is popped.
module jump_index_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      target_addr,
  input  logic [31:0]      pc_plus4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [25:0]      instr_index,
  output logic             err_misaligned,
  output logic             err_region,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  // Fill level of the FIFO. It is also readable by name as fifo_state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

  fifo_state_t fifo_state, fifo_state_nxt;

  // Entry layout: {index[25:0], misaligned, region}
  logic [27:0] head_q, head_d;
  logic [27:0] tail_q, tail_d;
  logic [27:0] new_entry;
  logic        push, pop;
  logic        new_err;

  logic [CNT_W-1:0] enc_q, err_q;

  // Only the region nibble of pc_plus4 matters.
  logic unused_pc_bits;
  assign unused_pc_bits = ^pc_plus4[27:0];

  assign in_ready  = (fifo_state != FULL);
  assign out_valid = (fifo_state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign new_entry = {target_addr[27:2],
                      (target_addr[1:0] != 2'b00),
                      (target_addr[31:28] != pc_plus4[31:28])};
  assign new_err   = new_entry[1] | new_entry[0];

  assign instr_index    = head_q[27:2];
  assign err_misaligned = head_q[1];
  assign err_region     = head_q[0];
  assign enc_count      = enc_q;
  assign err_count      = err_q;

  // FIFO state and storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_state <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fifo_state <= fifo_state_nxt;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Next fill level and where an incoming entry lands
  always_comb begin
    fifo_state_nxt = fifo_state;
    head_d         = head_q;
    tail_d         = tail_q;
    case (fifo_state)
      EMPTY: begin
        if (push) begin
          head_d         = new_entry;
          fifo_state_nxt = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          // The head leaves and the new entry replaces it directly.
          head_d = new_entry;
        end else if (push) begin
          tail_d         = new_entry;
          fifo_state_nxt = FULL;
        end else if (pop) begin
          fifo_state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low, so only a pop can happen here.
        if (pop) begin
          head_d         = tail_q;
          fifo_state_nxt = ONE;
        end
      end
      default: begin
        fifo_state_nxt = EMPTY;
      end
    endcase
  end

  // Saturating statistics counters; a clear wins over an increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_q <= '0;
      err_q <= '0;
    end else if (clr_counts) begin
      enc_q <= '0;
      err_q <= '0;
    end else if (push) begin
      if (!(&enc_q)) enc_q <= enc_q + CNT_W'(1);
      if (new_err && !(&err_q)) err_q <= err_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_jump_index_encoder.sv
`timescale 1ns/1ps
// Bench for jump_index_encoder. It runs two instances on the same stimulus:
// one with the default counter width and one with 4-bit counters, so that
// saturation can be checked.
module tb_jump_index_encoder;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, out_ready, clr_counts;
  logic [31:0] target_addr, pc_plus4;

  logic        in_ready, out_valid, err_misaligned, err_region;
  logic [25:0] instr_index;
  logic [15:0] enc_count, err_count;

  logic        in_ready_s, out_valid_s, err_misaligned_s, err_region_s;
  logic [25:0] instr_index_s;
  logic [3:0]  enc_count_s, err_count_s;

  jump_index_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .target_addr(target_addr), .pc_plus4(pc_plus4), .out_valid(out_valid),
    .out_ready(out_ready), .instr_index(instr_index),
    .err_misaligned(err_misaligned), .err_region(err_region),
    .clr_counts(clr_counts), .enc_count(enc_count), .err_count(err_count)
  );

  jump_index_encoder #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .target_addr(target_addr), .pc_plus4(pc_plus4), .out_valid(out_valid_s),
    .out_ready(out_ready), .instr_index(instr_index_s),
    .err_misaligned(err_misaligned_s), .err_region(err_region_s),
    .clr_counts(clr_counts), .enc_count(enc_count_s), .err_count(err_count_s)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Each model entry holds the raw request: {target_addr, pc_plus4[31:28]}.
  logic [35:0] exp_q[$];
  int          enc_m, err_m;
  logic [25:0] log_q[$];   // instr_index values the DUT delivered

  int  m_n;
  bit  m_push, m_pop, m_err;

  // Reference model. It tracks the requests by queue contents and counts
  // the pushes in plain integers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      enc_m = 0;
      err_m = 0;
    end else begin
      m_n    = exp_q.size();
      m_push = in_valid && (m_n < 2);
      m_pop  = (m_n > 0) && out_ready;
      m_err  = (target_addr[1:0] != 2'b00) || (target_addr[31:28] != pc_plus4[31:28]);
      if (clr_counts) begin
        enc_m = 0;
        err_m = 0;
      end else if (m_push) begin
        enc_m++;
        if (m_err) err_m++;
      end
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({target_addr, pc_plus4[31:28]});
    end
  end

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  logic [31:0] c_t;
  logic [3:0]  c_ph;

  // Checks the outputs against the model on every falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() != 2});
      check("in_ready_s", {31'd0, in_ready_s}, {31'd0, exp_q.size() != 2});
      if (exp_q.size() != 0) begin
        c_t  = exp_q[0][35:4];
        c_ph = exp_q[0][3:0];
        check("instr_index", {6'd0, instr_index}, {6'd0, c_t[27:2]});
        check("err_misaligned", {31'd0, err_misaligned}, {31'd0, c_t[1:0] != 2'b00});
        check("err_region", {31'd0, err_region}, {31'd0, c_t[31:28] != c_ph});
        if (c_t[1:0] == 2'b00 && c_t[31:28] == c_ph)
          check("round_trip", {c_ph, instr_index, 2'b00}, c_t);
        if (out_ready) log_q.push_back(instr_index);
      end
      check("enc_count", {16'd0, enc_count}, sat(enc_m, 65535));
      check("err_count", {16'd0, err_count}, sat(err_m, 65535));
      check("enc_count_s", {28'd0, enc_count_s}, sat(enc_m, 15));
      check("err_count_s", {28'd0, err_count_s}, sat(err_m, 15));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    in_valid   = 1'b0;
    clr_counts = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds a request until it is accepted. On return it is 1 ns after the push edge.
  task automatic drive_req(input logic [31:0] t, input logic [31:0] pc);
    bit r;
    bit done;
    done        = 1'b0;
    target_addr = t;
    pc_plus4    = pc;
    in_valid    = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=stalled required=accepted target=%h", t);
    end
    in_valid   = 1'b0;
    clr_counts = 1'b0;
  endtask

  logic [31:0] r_t, r_pc;

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    clr_counts  = 1'b0;
    target_addr = '0;
    pc_plus4    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset values
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr_index", {6'd0, instr_index}, 32'd0);
    check("rst_enc_count", {16'd0, enc_count}, 32'd0);
    check("rst_err_count", {16'd0, err_count}, 32'd0);
    idle(2);

    // Single request
    out_ready = 1'b1;
    drive_req(32'h0040_0020, 32'h0040_0004);
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_index", {6'd0, instr_index}, 32'h0010_0008);
    check("single_flags", {30'd0, err_misaligned, err_region}, 32'd0);
    check("single_enc", {16'd0, enc_count}, 32'd1);

    // A request with both error flags set
    drive_req(32'h1000_0002, 32'h0000_0010);
    check("err_index", {6'd0, instr_index}, 32'd0);
    check("err_flags", {30'd0, err_misaligned, err_region}, 32'd3);
    check("err_count_lit", {16'd0, err_count}, 32'd1);
    check("err_enc_lit", {16'd0, enc_count}, 32'd2);
    idle(2);

    // Backpressure: A and B fill the FIFO and C has to wait
    out_ready = 1'b0;
    log_q.delete();
    drive_req(32'h0040_0100, 32'h0040_0000);
    drive_req(32'h0040_0204, 32'h0040_0000);
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    target_addr = 32'h0040_0ff8;
    pc_plus4    = 32'h0040_0000;
    in_valid    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      check("bp_stable_A", {6'd0, instr_index}, 32'h0010_0040);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drive_req(32'h0040_0ff8, 32'h0040_0000);
    idle(3);
    check("bp_count", log_q.size(), 32'd3);
    if (log_q.size() == 3) begin
      check("bp_order_A", {6'd0, log_q[0]}, 32'h0010_0040);
      check("bp_order_B", {6'd0, log_q[1]}, 32'h0010_0081);
      check("bp_order_C", {6'd0, log_q[2]}, 32'h0010_03fe);
    end

    // Streaming 100 aligned same-region targets
    clr_counts = 1'b1;
    @(posedge clk);
    #1;
    clr_counts = 1'b0;
    log_q.delete();
    for (int i = 0; i < 100; i++) begin
      r_pc = $urandom;
      r_t  = {r_pc[31:28], 26'($urandom), 2'b00};
      drive_req(r_t, r_pc);
    end
    idle(2);
    check("stream_enc", {16'd0, enc_count}, 32'd100);
    check("stream_err", {16'd0, err_count}, 32'd0);
    check("stream_delivered", log_q.size(), 32'd100);

    // Saturation on the narrow instance
    clr_counts = 1'b1;
    @(posedge clk);
    #1;
    clr_counts = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_req($urandom, $urandom);
    end
    idle(2);
    check("sat_enc_s", {28'd0, enc_count_s}, 32'd15);
    check("sat_enc", {16'd0, enc_count}, 32'd20);
    clr_counts = 1'b1;
    drive_req(32'h0040_0020, 32'h0040_0004);
    check("clr_push_enc", {16'd0, enc_count}, 32'd0);
    check("clr_push_enc_s", {28'd0, enc_count_s}, 32'd0);
    idle(2);

    // Random valid/ready traffic, with some addresses in error
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      r_pc      = $urandom;
      r_t       = ($urandom_range(0, 3) == 0) ? $urandom : {r_pc[31:28], 26'($urandom), 2'b00};
      target_addr = r_t;
      pc_plus4    = r_pc;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(3);

    // Reset while the FIFO is full
    out_ready = 1'b0;
    drive_req(32'h0000_1000, 32'h0000_0000);
    drive_req(32'h0000_2000, 32'h0000_0000);
    idle(1);
    check("full_before_rst", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("async_rst_index", {6'd0, instr_index}, 32'd0);
    check("async_rst_enc", {16'd0, enc_count}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
